// File: rtl/output_serializer_if.sv
// Response bus between wishbone_master (producer) and output_serializer (consumer).
// out_en is only meaningful while out_ready is high.
interface output_serializer_if;
    logic        out_en;
    logic [31:0] out_status;
    logic [31:0] out_address;
    logic [31:0] out_data;
    logic [27:0] out_data_count;
    logic        out_ready;

    modport master (
        output out_en,
        output out_status,
        output out_address,
        output out_data,
        output out_data_count,
        input  out_ready
    );

    modport slave (
        input  out_en,
        input  out_status,
        input  out_address,
        input  out_data,
        input  out_data_count,
        output out_ready
    );
endinterface

// File: rtl/output_serializer.sv
// Turns wishbone_master responses into a byte stream for the host PHY: a 17-byte header
// (sync, status, count, address, data) or a 4-byte continuation word for burst reads.
module output_serializer #(
    parameter logic [7:0] SYNC_BYTE = 8'hDC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ih_reset_i,
    output_serializer_if.slave    rsp,
    output logic [7:0]            byte_data_o,
    output logic                  byte_valid_o,
    input  logic                  byte_ready_i,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_STATUS,
        ST_COUNT,
        ST_ADDR,
        ST_DATA
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [27:0] remaining_q, remaining_d;
    logic        capture;
    logic        xfer;

    logic [31:0] status_q;
    logic [31:0] address_q;
    logic [31:0] data_q;
    logic [27:0] count_q;
    logic [31:0] field_word;

    // Outputs decode straight from registered state, so async reset reaches them at once.
    assign byte_valid_o  = (state_q != ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign rsp.out_ready = (state_q == ST_IDLE);
    assign xfer          = byte_valid_o && byte_ready_i;

    // NOTE: every variable driven here gets a default first; a missed branch would
    // otherwise infer a latch instead of holding the registered value.
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        remaining_d = remaining_q;
        capture     = 1'b0;

        if (ih_reset_i) begin
            state_d     = ST_IDLE;
            byte_idx_d  = 2'd0;
            remaining_d = 28'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rsp.out_en) begin
                        capture    = 1'b1;
                        byte_idx_d = 2'd3;
                        if (remaining_q == 28'd0) begin
                            state_d     = ST_SYNC;
                            remaining_d = rsp.out_data_count;
                        end else begin
                            state_d     = ST_DATA;
                            remaining_d = remaining_q - 28'd1;
                        end
                    end
                end
                ST_SYNC: begin
                    if (xfer) begin
                        state_d    = ST_STATUS;
                        byte_idx_d = 2'd3;
                    end
                end
                ST_STATUS, ST_COUNT, ST_ADDR: begin
                    if (xfer) begin
                        // Index wraps 0 -> 3 exactly when the next field starts.
                        byte_idx_d = byte_idx_q - 2'd1;
                        if (byte_idx_q == 2'd0) begin
                            unique case (state_q)
                                ST_STATUS: state_d = ST_COUNT;
                                ST_COUNT:  state_d = ST_ADDR;
                                default:   state_d = ST_DATA;
                            endcase
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        byte_idx_d = byte_idx_q - 2'd1;
                        if (byte_idx_q == 2'd0) begin
                            state_d    = ST_IDLE;
                            byte_idx_d = 2'd0;
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    byte_idx_d = 2'd0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byte_idx_q  <= 2'd0;
            remaining_q <= 28'd0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            remaining_q <= remaining_d;
        end
    end

    // NOTE: the payload holding registers are deliberately not reset; they are only
    // observed outside IDLE, which is always entered through a capture that loads them.
    always_ff @(posedge clk) begin
        if (capture) begin
            status_q  <= rsp.out_status;
            address_q <= rsp.out_address;
            data_q    <= rsp.out_data;
            count_q   <= rsp.out_data_count;
        end
    end

    always_comb begin
        field_word = 32'h0;
        unique case (state_q)
            ST_STATUS: field_word = status_q;
            ST_COUNT:  field_word = {4'h0, count_q};
            ST_ADDR:   field_word = address_q;
            ST_DATA:   field_word = data_q;
            default:   field_word = 32'h0;
        endcase
    end

    always_comb begin
        byte_data_o = 8'h00;
        if (state_q == ST_SYNC) begin
            byte_data_o = SYNC_BYTE;
        end else if (state_q != ST_IDLE) begin
            byte_data_o = field_word[{byte_idx_q, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_output_serializer.sv
// Directed bench for output_serializer: header/continuation framing, backpressure,
// ih_reset flush and asynchronous reset, checked against hand-derived byte sequences.
module tb_output_serializer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ih_reset = 1'b0;
    logic       byte_ready = 1'b1;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       busy;

    output_serializer_if rsp ();

    output_serializer #(.SYNC_BYTE(8'hDC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ih_reset_i   (ih_reset),
        .rsp          (rsp),
        .byte_data_o  (byte_data),
        .byte_valid_o (byte_valid),
        .byte_ready_i (byte_ready),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    bit         pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic push_header(input logic [31:0] s, input logic [27:0] c,
                               input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back(8'hDC);
        push_word(s);
        push_word({4'h0, c});
        push_word(a);
        push_word(d);
    endtask

    task automatic send(input logic [31:0] s, input logic [31:0] a,
                        input logic [31:0] d, input logic [27:0] c);
        int n = 0;
        while (!rsp.out_ready && n < 100) begin
            step();
            n++;
        end
        check("send_ready", 64'(rsp.out_ready), 64'd1);
        rsp.out_en         = 1'b1;
        rsp.out_status     = s;
        rsp.out_address    = a;
        rsp.out_data       = d;
        rsp.out_data_count = c;
        step();
        rsp.out_en = 1'b0;
        check("cap_out_ready", 64'(rsp.out_ready), 64'd0);
        check("cap_valid", 64'(byte_valid), 64'd1);
        check("cap_busy", 64'(busy), 64'd1);
    endtask

    // Transfers up to `limit` bytes of exp_q, checking each presented byte (stalls included).
    task automatic drain(input string tag, input bit bp, input int limit, output int cycles);
        int n = (limit < exp_q.size()) ? limit : exp_q.size();
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 400) begin
            byte_ready = bp ? pat[cyc % 6] : 1'b1;
            #1;
            check($sformatf("%s_byte%0d", tag, k), 64'(byte_data), 64'(exp_q[k]));
            check($sformatf("%s_valid%0d", tag, k), 64'(byte_valid), 64'd1);
            check($sformatf("%s_oready%0d", tag, k), 64'(rsp.out_ready), 64'd0);
            if (byte_valid && byte_ready) k++;
            step();
            cyc++;
        end
        check($sformatf("%s_count", tag), 64'(k), 64'(n));
        byte_ready = 1'b1;
        exp_q.delete();
        cycles = cyc;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 64'(byte_valid), 64'd0);
        check({tag, "_oready"}, 64'(rsp.out_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_data"}, 64'(byte_data), 64'd0);
    endtask

    initial begin
        int cyc;
        rsp.out_en         = 1'b0;
        rsp.out_status     = '0;
        rsp.out_address    = '0;
        rsp.out_data       = '0;
        rsp.out_data_count = '0;

        // Reset state
        #1;
        check_idle("reset");
        #20 rst_n = 1'b1;
        step();
        check_idle("post_reset");

        // 1 Ping: 17 bytes on 17 consecutive cycles
        send(32'hFFFF_FFFF, 32'h0, 32'h0, 28'h0);
        push_header(32'hFFFF_FFFF, 28'h0, 32'h0, 32'h0);
        drain("ping", 1'b0, 99, cyc);
        check("ping_cycles", 64'(cyc), 64'd17);
        check_idle("ping_done");

        // 2 Read burst: header count=2, two continuation words, then a fresh header
        send(32'hFFFF_FFFD, 32'h0100_0000, 32'h1122_3344, 28'd2);
        push_header(32'hFFFF_FFFD, 28'd2, 32'h0100_0000, 32'h1122_3344);
        drain("burst_hdr", 1'b0, 99, cyc);
        send(32'h1234_5678, 32'h9ABC_DEF0, 32'hAABB_CCDD, 28'd7);
        push_word(32'hAABB_CCDD);
        drain("cont1", 1'b0, 99, cyc);
        check("cont1_cycles", 64'(cyc), 64'd4);
        check_idle("cont1_done");
        send(32'h0, 32'h0, 32'h5566_7788, 28'd0);
        push_word(32'h5566_7788);
        drain("cont2", 1'b0, 99, cyc);
        send(32'h0000_0001, 32'h0000_0010, 32'hDEAD_BEEF, 28'd0);
        push_header(32'h0000_0001, 28'd0, 32'h0000_0010, 32'hDEAD_BEEF);
        drain("burst_next", 1'b0, 99, cyc);
        check_idle("burst_done");

        // 3 Count field split into 0A BC DE F1
        send(32'h0, 32'h0, 32'h0, 28'hABC_DEF1);
        push_header(32'h0, 28'hABC_DEF1, 32'h0, 32'h0);
        drain("count", 1'b0, 99, cyc);

        // ih_reset together with out_en while idle: flush wins, remaining cleared
        rsp.out_en     = 1'b1;
        rsp.out_data   = 32'h0BAD_0BAD;
        ih_reset       = 1'b1;
        step();
        rsp.out_en = 1'b0;
        ih_reset   = 1'b0;
        check_idle("flush_idle");

        // 4 Backpressure on ping: header (not continuation) proves remaining was cleared
        send(32'hFFFF_FFFF, 32'h0, 32'h0, 28'h0);
        push_header(32'hFFFF_FFFF, 28'h0, 32'h0, 32'h0);
        drain("bp", 1'b1, 99, cyc);
        check_idle("bp_done");

        // 5 ih_reset after 5 bytes of a header with count=3
        send(32'hCAFE_0001, 32'h0000_2000, 32'h7777_8888, 28'd3);
        push_header(32'hCAFE_0001, 28'd3, 32'h0000_2000, 32'h7777_8888);
        drain("flush_part", 1'b0, 5, cyc);
        check("flush_busy_before", 64'(busy), 64'd1);
        ih_reset = 1'b1;
        step();
        ih_reset = 1'b0;
        check_idle("flush_mid");
        send(32'h0000_00AA, 32'h0000_0004, 32'h0102_0304, 28'd1);
        push_header(32'h0000_00AA, 28'd1, 32'h0000_0004, 32'h0102_0304);
        drain("flush_next", 1'b0, 99, cyc);

        // 6 Async reset mid-continuation (remaining=1 from the header above)
        send(32'h0, 32'h0, 32'hCAFE_F00D, 28'd0);
        push_word(32'hCAFE_F00D);
        drain("arst_part", 1'b0, 2, cyc);
        check("arst_valid_before", 64'(byte_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_idle("arst_now");
        #3 rst_n = 1'b1;
        step();
        send(32'h0000_5555, 32'h0000_0008, 32'h0F0E_0D0C, 28'd0);
        push_header(32'h0000_5555, 28'd0, 32'h0000_0008, 32'h0F0E_0D0C);
        drain("arst_next", 1'b0, 99, cyc);
        check_idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
